loop_kernel_arr: RTL and testbench
==================================

// Module: loop_kernel_arr
// PURPOSE
//   Parametrised array kernel: on start, optionally fills a DEPTH x WIDTH on-chip array with
//   init_i+k (k=0..DEPTH-1), reads it back, and returns the truncated sum. A zero init skips
//   memory and returns 0. A host control port takes priority over the kernel's array port;
//   the kernel stalls while the host holds it. Generalises the single-entry compare/write kernel.
// PARAMETERS
//   WIDTH  8   array element width and init_i width
//   DEPTH  4   array entries (>=2); AW = $clog2(DEPTH)
//   RW     16  result width; sum truncated mod 2^RW
//   MODE   0   0 = fill then sum; 1 = sum existing contents (no fill phase)
// PORTS
//   clk                  in   1      clock, all state on posedge
//   rst_n                in   1      asynchronous, active-low reset
//   r_enable             in   1      start/load; while high: reload init, state<=CHECK
//   init_i               in   WIDTH  seed value, sampled every cycle r_enable is high
//   controlArr           in   1      host owns array port when high
//   controlArrWEnable_a  in   1      host write enable
//   controlArrAddr_a     in   AW     host address
//   controlArrWData_a    in   WIDTH  host write data
//   controlArrRData_a    out  WIDTH  host read data, 1-cycle latency; 'x when controlArr low
//   w_enable             out  1      result valid, held high until next start or reset
//   result               out  RW     sum; valid while w_enable high
// BEHAVIOUR
//   Reset (rst_n low, async): state<=DONE, w_enable<=0, result<=0, idx<=0, acc<=0,
//     rd_valid<=0. Array contents are not reset.
//   r_enable high (sync, overrides everything): seed<=init_i, acc<=0, idx<=0, w_enable<=0,
//     state<=CHECK. Edge numbering below: edge 1 = first posedge with r_enable low.
//   States: CHECK -> (seed==0 ? DONE : MODE0 ? FILL : SUM); FILL -> SUM; SUM -> DRAIN -> DONE.
//   CHECK: 1 cycle, no memory access.
//   FILL: write mem[idx]=seed+idx (mod 2^WIDTH); idx++ per cycle; idx==DEPTH-1 -> SUM, idx<=0.
//   SUM: issue read idx; rd_valid<=1; idx==DEPTH-1 -> DRAIN. DRAIN: 1 cycle, no issue.
//   Accumulate: any cycle rd_valid is high, acc<=acc+zext(rdata); rd_valid<=0 unless re-issued.
//   DONE: every cycle w_enable<=1, result<=acc[RW-1:0].
//   Latency (no stalls): w_enable rises at edge 2*DEPTH+3 (MODE0), DEPTH+3 (MODE1), 2 (seed 0).
//   Host priority: controlArr high muxes host signals onto the array; kernel holds state
//     and idx (no write, no issue) in FILL/SUM. Read issued the edge before controlArr rose
//     is still accumulated (data returns via registered read address). Each stall cycle adds
//     exactly one cycle to latency. CHECK, DRAIN and DONE do not stall.
//   Array: write when enable; registered read address; read during write returns 'x
//     (kernel never reads and writes in same cycle).
//   Width: acc is RW bits, wraps mod 2^RW; element addition wraps mod 2^WIDTH before write.
//   Reset mid-operation: outputs drop asynchronously; restart needs a fresh r_enable pulse.
//   r_enable mid-operation: restarts cleanly, w_enable low from the next edge.
// STRUCTURE
//   Package loop_kernel_pkg: state enum {CHECK,FILL,SUM,DRAIN,DONE}, MODE_FILL_SUM=0,
//     MODE_SUM_ONLY=1.
//   Sub-module arr_bank #(WIDTH,DEPTH): single-port sync-write RAM, registered read address,
//     no reset; host/kernel mux stays in the top.
// TESTING (WIDTH=8, DEPTH=4, RW=16 unless stated)
//   1 host preloads 9s; init_i=0 -> w_enable high at edge 2, result=0; host readback all 9s.
//   2 init_i=5 -> mem={5,6,7,8}, w_enable at edge 11, result=26.
//   3 init_i=254 -> mem={254,255,0,1}, result=510 (element wrap, no sum wrap).
//   4 init_i=5, controlArr high 3 cycles mid-FILL, host reads addr 0 -> host sees 5;
//     result=26, w_enable at edge 14.
//   5 rst_n low during SUM -> w_enable=0, result=0 before next edge; re-start init 1 -> 10.
//   6 MODE=1, host preloads {1,2,3,4}, init_i=1 -> result=10 at edge 7, contents unchanged.

Source files
------------

// File: rtl/loop_kernel_pkg.sv
// Package: loop_kernel_pkg
// Shared kernel FSM state type and the MODE encodings for loop_kernel_arr.
//   state_t        : CHECK, FILL, SUM, DRAIN, DONE
//   MODE_FILL_SUM  : kernel fills the array with seed+k, then sums it
//   MODE_SUM_ONLY  : kernel sums whatever the array already holds
package loop_kernel_pkg;

    typedef enum logic [2:0] {
        CHECK,
        FILL,
        SUM,
        DRAIN,
        DONE
    } state_t;

    localparam int MODE_FILL_SUM = 0;
    localparam int MODE_SUM_ONLY = 1;

endpackage

// File: rtl/loop_kernel_arr_bank.sv
// Module: arr_bank
// Single-port DEPTH x WIDTH RAM with synchronous write and a registered read
// address, so read data appears one cycle after the address is presented.
// No reset: contents and the address register power up undefined.
// Ports:
//   clk    in   1      clock
//   we     in   1      write enable
//   addr   in   AW     shared read/write address
//   wdata  in   WIDTH  write data
//   rdata  out  WIDTH  data at the address registered on the previous edge
module arr_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    addr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        addr_q <= addr;
    end

    // Reading the registered address keeps this a block-RAM style read port.
    assign rdata = mem[addr_q];

endmodule

// File: rtl/loop_kernel_arr.sv
// Module: loop_kernel_arr
// Array kernel: on a start pulse it optionally fills the array with seed+k,
// reads every entry back and reports the truncated sum. A zero seed skips the
// array entirely and reports 0. A host port can take over the array at any
// time; the kernel freezes its FILL/SUM progress while the host holds it.
// Ports:
//   clk                  in   1      clock
//   rst_n                in   1      asynchronous active-low reset
//   r_enable             in   1      start/reload, overrides all kernel state
//   init_i               in   WIDTH  seed, captured while r_enable is high
//   controlArr           in   1      host owns the array port
//   controlArrWEnable_a  in   1      host write enable
//   controlArrAddr_a     in   AW     host address
//   controlArrWData_a    in   WIDTH  host write data
//   controlArrRData_a    out  WIDTH  host read data (1-cycle latency)
//   w_enable             out  1      result valid
//   result               out  RW     truncated sum
module loop_kernel_arr
    import loop_kernel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int RW    = 16,
    parameter int MODE  = 0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_enable,
    input  logic [WIDTH-1:0] init_i,
    input  logic             controlArr,
    input  logic             controlArrWEnable_a,
    input  logic [AW-1:0]    controlArrAddr_a,
    input  logic [WIDTH-1:0] controlArrWData_a,
    output logic [WIDTH-1:0] controlArrRData_a,
    output logic             w_enable,
    output logic [RW-1:0]    result
);

    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
    localparam bit            HAS_FILL   = (MODE != MODE_SUM_ONLY);

    state_t           state;
    logic [WIDTH-1:0] seed;
    logic [AW-1:0]    idx;
    logic [RW-1:0]    acc;
    logic             rd_valid;
    logic             host_rd_q;

    logic             kern_we;
    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;

    // Host has absolute priority on the array port; the kernel only drives it
    // when the host is idle and no reload is in progress. The element value
    // wraps at WIDTH bits before it is written.
    always_comb begin
        kern_we   = (state == FILL) && !controlArr && !r_enable;
        mem_we    = controlArr ? controlArrWEnable_a : kern_we;
        mem_addr  = controlArr ? controlArrAddr_a    : idx;
        mem_wdata = controlArr ? controlArrWData_a   : WIDTH'(seed + WIDTH'(idx));
    end

    arr_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Host read data belongs to the host only on the cycle after it owned the
    // port, matching the registered read address of the bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_rd_q <= 1'b0;
        end else begin
            host_rd_q <= controlArr;
        end
    end

    assign controlArrRData_a = host_rd_q ? mem_rdata : {WIDTH{1'bx}};

    // Kernel FSM. A read issued in SUM returns data on the following cycle, so
    // accumulation is keyed on rd_valid rather than on the state; this also
    // lets a read issued just before a host takeover still land in acc, and
    // DRAIN exists only to collect the final read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DONE;
            w_enable <= 1'b0;
            result   <= '0;
            idx      <= '0;
            acc      <= '0;
            rd_valid <= 1'b0;
            seed     <= '0;
        end else if (r_enable) begin
            seed     <= init_i;
            acc      <= '0;
            idx      <= '0;
            w_enable <= 1'b0;
            rd_valid <= 1'b0;
            state    <= CHECK;
        end else begin
            if (rd_valid) begin
                acc <= acc + RW'(mem_rdata);
            end
            rd_valid <= 1'b0;

            case (state)
                CHECK: begin
                    if (seed == '0) begin
                        state <= DONE;
                    end else if (HAS_FILL) begin
                        state <= FILL;
                    end else begin
                        state <= SUM;
                    end
                end

                FILL: begin
                    if (!controlArr) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= SUM;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                SUM: begin
                    if (!controlArr) begin
                        rd_valid <= 1'b1;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= DRAIN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                DRAIN: begin
                    state <= DONE;
                end

                DONE: begin
                    w_enable <= 1'b1;
                    result   <= acc;
                end

                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loop_kernel_arr.sv
// Testbench for loop_kernel_arr. Two instances share every input: one in
// fill-then-sum mode and one in sum-only mode, each with its own array.
module tb_loop_kernel_arr;
    import loop_kernel_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int RW    = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             r_enable = 1'b0;
    logic [WIDTH-1:0] init_i = '0;
    logic             control_arr = 1'b0;
    logic             host_we = 1'b0;
    logic [1:0]       host_addr = '0;
    logic [WIDTH-1:0] host_wdata = '0;

    logic [WIDTH-1:0] rdata0, rdata1;
    logic             wen0, wen1;
    logic [RW-1:0]    res0, res1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    loop_kernel_arr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RW(RW), .MODE(MODE_FILL_SUM)) dut0 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .r_enable            (r_enable),
        .init_i              (init_i),
        .controlArr          (control_arr),
        .controlArrWEnable_a (host_we),
        .controlArrAddr_a    (host_addr),
        .controlArrWData_a   (host_wdata),
        .controlArrRData_a   (rdata0),
        .w_enable            (wen0),
        .result              (res0)
    );

    loop_kernel_arr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RW(RW), .MODE(MODE_SUM_ONLY)) dut1 (
        .clk                 (clk),
        .rst_n               (rst_n),
        .r_enable            (r_enable),
        .init_i              (init_i),
        .controlArr          (control_arr),
        .controlArrWEnable_a (host_we),
        .controlArrAddr_a    (host_addr),
        .controlArrWData_a   (host_wdata),
        .controlArrRData_a   (rdata1),
        .w_enable            (wen1),
        .result              (res1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model. Each instance is reduced to: a target sum computed at
    // start time, a number of stallable work steps, and a count of edges that
    // made progress. The result appears on the edge where progress reaches
    // 1 (check) + work + 1 (drain, if any work) + 1 (done).
    logic [WIDTH-1:0] mdl_mem [2][DEPTH];
    logic             mdl_wen [2];
    logic [RW-1:0]    mdl_res [2];
    logic [RW-1:0]    mdl_target [2];
    int               mdl_prog [2];
    int               mdl_total [2];
    int               mdl_work [2];

    function automatic logic [RW-1:0] fillSum(input logic [WIDTH-1:0] s);
        logic [RW-1:0] sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [WIDTH-1:0] e = WIDTH'(s + WIDTH'(k));
            sum = sum + RW'(e);
        end
        return sum;
    endfunction

    function automatic logic [RW-1:0] memSum(input int m);
        logic [RW-1:0] sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sum = sum + RW'(mdl_mem[m][k]);
        end
        return sum;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mdl_wen[m]    <= 1'b0;
                mdl_res[m]    <= '0;
                mdl_target[m] <= '0;
                mdl_work[m]   <= 0;
                mdl_prog[m]   <= 1;
                mdl_total[m]  <= 2;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                if (control_arr && host_we) begin
                    mdl_mem[m][host_addr] <= host_wdata;
                end
                if (r_enable) begin
                    mdl_wen[m]  <= 1'b0;
                    mdl_prog[m] <= 0;
                    if (init_i == '0) begin
                        mdl_work[m]   <= 0;
                        mdl_target[m] <= '0;
                        mdl_total[m]  <= 2;
                    end else if (m == 0) begin
                        mdl_work[m]   <= 2 * DEPTH;
                        mdl_target[m] <= fillSum(init_i);
                        mdl_total[m]  <= 2 * DEPTH + 3;
                        for (int k = 0; k < DEPTH; k++) begin
                            mdl_mem[0][k] <= WIDTH'(init_i + WIDTH'(k));
                        end
                    end else begin
                        mdl_work[m]   <= DEPTH;
                        mdl_target[m] <= memSum(1);
                        mdl_total[m]  <= DEPTH + 3;
                    end
                end else if (!(control_arr && mdl_prog[m] >= 1 && mdl_prog[m] <= mdl_work[m])) begin
                    mdl_prog[m] <= mdl_prog[m] + 1;
                    if (mdl_prog[m] + 1 == mdl_total[m]) begin
                        mdl_wen[m] <= 1'b1;
                        mdl_res[m] <= mdl_target[m];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("w_enable0", 32'(wen0), 32'(mdl_wen[0]));
        checkOutput("result0",   32'(res0), 32'(mdl_res[0]));
        checkOutput("w_enable1", 32'(wen1), 32'(mdl_wen[1]));
        checkOutput("result1",   32'(res1), 32'(mdl_res[1]));
    end

    task automatic hostWrite(input logic [1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        control_arr = 1'b1;
        host_we     = 1'b1;
        host_addr   = a;
        host_wdata  = d;
        @(negedge clk);
        host_we     = 1'b0;
        control_arr = 1'b0;
    endtask

    task automatic hostRead(input logic [1:0] a, output logic [WIDTH-1:0] d0, output logic [WIDTH-1:0] d1);
        @(negedge clk);
        control_arr = 1'b1;
        host_we     = 1'b0;
        host_addr   = a;
        @(negedge clk);
        d0 = rdata0;
        d1 = rdata1;
        checkOutput("host_rd0", 32'(rdata0), 32'(mdl_mem[0][a]));
        checkOutput("host_rd1", 32'(rdata1), 32'(mdl_mem[1][a]));
        control_arr = 1'b0;
    endtask

    // Start pulse, then count edges until both instances raise w_enable.
    // Optionally the host holds the array for stall_len edges starting after
    // edge stall_at, reading address 0 throughout.
    task automatic applyStimulus(input logic [WIDTH-1:0] seed, input int stall_at, input int stall_len,
                                 output int rise0, output int rise1, output logic [WIDTH-1:0] seen0);
        @(negedge clk);
        r_enable = 1'b1;
        init_i   = seed;
        @(negedge clk);
        r_enable = 1'b0;
        init_i   = WIDTH'($urandom);
        rise0 = -1;
        rise1 = -1;
        seen0 = '0;
        for (int n = 1; n <= 60 && (rise0 < 0 || rise1 < 0); n++) begin
            @(negedge clk);
            if (wen0 && rise0 < 0) rise0 = n;
            if (wen1 && rise1 < 0) rise1 = n;
            if (stall_len > 0 && n >= stall_at + 1 && n <= stall_at + stall_len) begin
                if (n == stall_at + 1) seen0 = rdata0;
                checkOutput("stall_rd0", 32'(rdata0), 32'(mdl_mem[0][0]));
                checkOutput("stall_rd1", 32'(rdata1), 32'(mdl_mem[1][0]));
            end
            if (stall_len > 0 && n == stall_at) begin
                control_arr = 1'b1;
                host_we     = 1'b0;
                host_addr   = 2'd0;
            end
            if (n == stall_at + stall_len) control_arr = 1'b0;
        end
        control_arr = 1'b0;
        if (rise0 < 0) checkOutput("timeout0", 0, 1);
        if (rise1 < 0) checkOutput("timeout1", 0, 1);
    endtask

    initial begin
        int r0, r1;
        logic [WIDTH-1:0] s0, d0, d1;
        logic [WIDTH-1:0] seed;
        int st_at, st_len;

        repeat (3) @(negedge clk);
        checkOutput("reset_wen0", 32'(wen0), 0);
        checkOutput("reset_res0", 32'(res0), 0);
        checkOutput("reset_wen1", 32'(wen1), 0);
        rst_n = 1'b1;

        // Host preload of 9s, zero seed, readback.
        for (int a = 0; a < DEPTH; a++) hostWrite(2'(a), 8'd9);
        applyStimulus(8'd0, 0, 0, r0, r1, s0);
        checkOutput("t1_rise0", r0, 2);
        checkOutput("t1_rise1", r1, 2);
        checkOutput("t1_res0", 32'(res0), 0);
        for (int a = 0; a < DEPTH; a++) begin
            hostRead(2'(a), d0, d1);
            checkOutput("t1_rb0", 32'(d0), 9);
            checkOutput("t1_rb1", 32'(d1), 9);
        end

        applyStimulus(8'd5, 0, 0, r0, r1, s0);
        checkOutput("t2_rise0", r0, 11);
        checkOutput("t2_res0", 32'(res0), 26);
        checkOutput("t2_rise1", r1, 7);
        checkOutput("t2_res1", 32'(res1), 36);

        applyStimulus(8'd254, 0, 0, r0, r1, s0);
        checkOutput("t3_res0", 32'(res0), 510);
        hostRead(2'd1, d0, d1);
        checkOutput("t3_mem1", 32'(d0), 255);
        hostRead(2'd2, d0, d1);
        checkOutput("t3_mem2", 32'(d0), 0);

        applyStimulus(8'd5, 2, 3, r0, r1, s0);
        checkOutput("t4_host_sees", 32'(s0), 5);
        checkOutput("t4_res0", 32'(res0), 26);
        checkOutput("t4_rise0", r0, 14);
        checkOutput("t4_rise1", r1, 10);

        // Reset during SUM, then restart.
        @(negedge clk);
        r_enable = 1'b1;
        init_i   = 8'd5;
        @(negedge clk);
        r_enable = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_wen0", 32'(wen0), 0);
        checkOutput("t5_res0", 32'(res0), 0);
        checkOutput("t5_res1", 32'(res1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'd1, 0, 0, r0, r1, s0);
        checkOutput("t5_restart_res0", 32'(res0), 10);

        // Restart mid-operation with a new seed.
        @(negedge clk);
        r_enable = 1'b1;
        init_i   = 8'd5;
        @(negedge clk);
        r_enable = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(8'd7, 0, 0, r0, r1, s0);
        checkOutput("restart_rise0", r0, 11);
        checkOutput("restart_res0", 32'(res0), 34);

        // Sum-only over host-preloaded contents.
        for (int a = 0; a < DEPTH; a++) hostWrite(2'(a), 8'(a + 1));
        applyStimulus(8'd1, 0, 0, r0, r1, s0);
        checkOutput("t6_rise1", r1, 7);
        checkOutput("t6_res1", 32'(res1), 10);
        checkOutput("t6_res0", 32'(res0), 10);
        for (int a = 0; a < DEPTH; a++) begin
            hostRead(2'(a), d0, d1);
            checkOutput("t6_rb1", 32'(d1), a + 1);
        end

        // Randomized runs.
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                hostWrite(2'($urandom_range(0, 3)), WIDTH'($urandom));
                hostWrite(2'($urandom_range(0, 3)), WIDTH'($urandom));
            end
            case ($urandom_range(0, 9))
                0:       seed = 8'd0;
                1:       seed = WIDTH'(250 + $urandom_range(0, 5));
                default: seed = WIDTH'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) begin
                st_at  = $urandom_range(2, 9);
                st_len = $urandom_range(1, 4);
            end else begin
                st_at  = 0;
                st_len = 0;
            end
            applyStimulus(seed, st_at, st_len, r0, r1, s0);
            hostRead(2'($urandom_range(0, 3)), d0, d1);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
